// File: rtl/ex_stage_pkg.sv
// Shared constants for the execute stage: op class / function codes and bus widths.
// Datapath width and the divider step count are fixed here for every user.
package ex_stage_pkg;

  localparam int XLEN       = 32;
  localparam int DIV_STEPS  = XLEN;
  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 3;
  localparam int ALUFUN_W   = 3;
  localparam int SHAMT_W    = $clog2(XLEN);
  localparam int DIV_CNT_W  = $clog2(DIV_STEPS);

  typedef enum logic [ALUOP_W-1:0] {
    OP_NOP   = 3'd0,
    OP_LOGIC = 3'd1,
    OP_SHIFT = 3'd2,
    OP_ARITH = 3'd3,
    OP_DIV   = 3'd4
  } aluop_e;

  localparam logic [ALUFUN_W-1:0] FUN_AND  = 3'd0;
  localparam logic [ALUFUN_W-1:0] FUN_OR   = 3'd1;
  localparam logic [ALUFUN_W-1:0] FUN_XOR  = 3'd2;

  localparam logic [ALUFUN_W-1:0] FUN_SLL  = 3'd0;
  localparam logic [ALUFUN_W-1:0] FUN_SRL  = 3'd1;
  localparam logic [ALUFUN_W-1:0] FUN_SRA  = 3'd2;

  localparam logic [ALUFUN_W-1:0] FUN_ADD  = 3'd0;
  localparam logic [ALUFUN_W-1:0] FUN_SUB  = 3'd1;
  localparam logic [ALUFUN_W-1:0] FUN_SLT  = 3'd2;
  localparam logic [ALUFUN_W-1:0] FUN_SLTU = 3'd3;

  localparam logic [ALUFUN_W-1:0] FUN_DIV  = 3'd0;
  localparam logic [ALUFUN_W-1:0] FUN_DIVU = 3'd1;
  localparam logic [ALUFUN_W-1:0] FUN_REM  = 3'd2;
  localparam logic [ALUFUN_W-1:0] FUN_REMU = 3'd3;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/ex_divider.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// signs re-applied combinationally on the held quotient/remainder.
module ex_divider
  import ex_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            signed_op,
  input  logic            want_rem,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [DIV_CNT_W-1:0] LAST_STEP = DIV_CNT_W'(DIV_STEPS - 1);

  logic [DIV_CNT_W-1:0] cnt;
  logic [XLEN-1:0]      quo;
  logic [XLEN-1:0]      rem;
  logic [XLEN-1:0]      dvs;
  logic                 neg_q;
  logic                 neg_r;
  logic                 rem_sel;
  logic [XLEN:0]        trial;
  logic [XLEN:0]        diff;

  // Partial remainder shifted left with the next dividend bit; fits because rem < dvs.
  assign trial = {rem, quo[XLEN-1]};
  assign diff  = trial - {1'b0, dvs};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      rem_sel <= 1'b0;
      busy    <= 1'b0;
    end else if (start) begin
      cnt     <= '0;
      quo     <= magnitude(dividend, signed_op);
      rem     <= '0;
      dvs     <= magnitude(divisor, signed_op);
      neg_q   <= signed_op & (dividend[XLEN-1] ^ divisor[XLEN-1]);
      neg_r   <= signed_op & dividend[XLEN-1];
      rem_sel <= want_rem;
      busy    <= 1'b1;
    end else if (busy) begin
      if (!diff[XLEN]) begin
        rem <= diff[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        rem <= trial[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end
      cnt <= cnt + DIV_CNT_W'(1);
      if (cnt == LAST_STEP) begin
        busy <= 1'b0;
      end
    end
  end

  // High during the final step; result is valid from the following cycle on.
  assign done = busy & (cnt == LAST_STEP);

  always_comb begin
    result = '0;
    if (rem_sel) begin
      result = neg_r ? (~rem + 1'b1) : rem;
    end else begin
      result = neg_q ? (~quo + 1'b1) : quo;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus iterative divide, with a valid/ready
// result register toward EX/MEM and a stall request while a divide is running.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALUOP_W-1:0]    aluop,
  input  logic [ALUFUN_W-1:0]   alufun,
  input  logic [XLEN-1:0]       reg1,
  input  logic [XLEN-1:0]       reg2,
  input  logic [REG_ADDR_W-1:0] wd,
  input  logic                  wreg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_wdata,
  output logic [REG_ADDR_W-1:0] out_wd,
  output logic                  out_wreg,
  output logic                  stall_req
);

  // state  | meaning
  // IDLE   | accepting ops; ALU/special-case results loaded next edge
  // BUSY   | divider stepping, ID stalled
  // DONE   | divide finished, waiting for the result register to free up
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state;
  state_e state_nx;

  logic [XLEN-1:0]       alu_res;
  logic                  op_known;
  logic                  div_iter;
  logic                  div_signed;
  logic                  div_rem;
  logic [SHAMT_W-1:0]    shamt;
  logic                  res_free;
  logic                  accept;
  logic                  div_start;
  logic                  div_busy;
  logic                  div_done;
  logic [XLEN-1:0]       div_result;
  logic [REG_ADDR_W-1:0] lat_wd;
  logic                  lat_wreg;

  assign shamt    = reg2[SHAMT_W-1:0];
  assign res_free = ~out_valid | out_ready;
  assign in_ready = (state == S_IDLE) & res_free;
  assign accept   = in_valid & in_ready & ~flush;
  assign div_start = accept & div_iter;

  always_comb begin
    alu_res    = '0;
    op_known   = 1'b0;
    div_iter   = 1'b0;
    div_signed = 1'b0;
    div_rem    = 1'b0;
    case (aluop)
      OP_LOGIC: begin
        case (alufun)
          FUN_AND: begin alu_res = reg1 & reg2; op_known = 1'b1; end
          FUN_OR:  begin alu_res = reg1 | reg2; op_known = 1'b1; end
          FUN_XOR: begin alu_res = reg1 ^ reg2; op_known = 1'b1; end
          default: ;
        endcase
      end
      OP_SHIFT: begin
        case (alufun)
          FUN_SLL: begin alu_res = reg1 << shamt; op_known = 1'b1; end
          FUN_SRL: begin alu_res = reg1 >> shamt; op_known = 1'b1; end
          FUN_SRA: begin alu_res = $unsigned($signed(reg1) >>> shamt); op_known = 1'b1; end
          default: ;
        endcase
      end
      OP_ARITH: begin
        case (alufun)
          FUN_ADD:  begin alu_res = reg1 + reg2; op_known = 1'b1; end
          FUN_SUB:  begin alu_res = reg1 - reg2; op_known = 1'b1; end
          FUN_SLT:  begin alu_res = {{(XLEN-1){1'b0}}, $signed(reg1) < $signed(reg2)}; op_known = 1'b1; end
          FUN_SLTU: begin alu_res = {{(XLEN-1){1'b0}}, reg1 < reg2}; op_known = 1'b1; end
          default: ;
        endcase
      end
      OP_DIV: begin
        case (alufun)
          FUN_DIV, FUN_DIVU, FUN_REM, FUN_REMU: begin
            op_known   = 1'b1;
            div_signed = (alufun == FUN_DIV) | (alufun == FUN_REM);
            div_rem    = (alufun == FUN_REM) | (alufun == FUN_REMU);
            // Corner cases resolve without iterating, like ordinary ALU ops.
            if (reg2 == '0) begin
              alu_res = div_rem ? reg1 : '1;
            end else if (div_signed && (reg1 == INT_MIN) && (reg2 == '1)) begin
              alu_res = div_rem ? '0 : INT_MIN;
            end else begin
              div_iter = 1'b1;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  ex_divider u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .signed_op (div_signed),
    .want_rem  (div_rem),
    .dividend  (reg1),
    .divisor   (reg2),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (div_start) state_nx = S_BUSY;
      S_BUSY:  if (div_done)  state_nx = S_DONE;
      S_DONE:  if (res_free)  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) begin
      state_nx = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_wdata <= '0;
      out_wd    <= '0;
      out_wreg  <= 1'b0;
      lat_wd    <= '0;
      lat_wreg  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && !div_iter) begin
        out_valid <= 1'b1;
        out_wdata <= alu_res;
        out_wd    <= wd;
        out_wreg  <= wreg & op_known;
      end
      if (div_start) begin
        lat_wd   <= wd;
        lat_wreg <= wreg;
      end
      if ((state == S_DONE) && res_free) begin
        out_valid <= 1'b1;
        out_wdata <= div_result;
        out_wd    <= lat_wd;
        out_wreg  <= lat_wreg;
      end
    end
  end

  assign stall_req = ((state == S_BUSY) & div_busy) | (state == S_DONE);

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expectations queued at issue, compared as results drain.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  aluop = '0;
  logic [2:0]  alufun = '0;
  logic [31:0] reg1 = '0;
  logic [31:0] reg2 = '0;
  logic [4:0]  wd = '0;
  logic        wreg = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_wdata;
  logic [4:0]  out_wd;
  logic        out_wreg;
  logic        stall_req;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
  } exp_t;
  exp_t exp_q[$];

  ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .alufun(alufun), .reg1(reg1), .reg2(reg2), .wd(wd), .wreg(wreg),
    .out_valid(out_valid), .out_ready(out_ready), .out_wdata(out_wdata),
    .out_wd(out_wd), .out_wreg(out_wreg), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result got wdata=%h wd=%0d wreg=%0b", out_wdata, out_wd, out_wreg);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({out_wdata, out_wd, out_wreg} !== {e.wdata, e.wd, e.wreg}) begin
          failures++;
          $display("FAIL result got wdata=%h wd=%0d wreg=%0b want wdata=%h wd=%0d wreg=%0b",
                   out_wdata, out_wd, out_wreg, e.wdata, e.wd, e.wreg);
        end
      end
    end
  end

  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [2:0] fun,
                                         input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sr;
    sa = a;
    sb = b;
    sr = '0;
    case ({op, fun})
      {OP_LOGIC, FUN_AND}:  return a & b;
      {OP_LOGIC, FUN_OR}:   return a | b;
      {OP_LOGIC, FUN_XOR}:  return a ^ b;
      {OP_SHIFT, FUN_SLL}:  return a << b[4:0];
      {OP_SHIFT, FUN_SRL}:  return a >> b[4:0];
      {OP_SHIFT, FUN_SRA}:  begin sr = sa >>> b[4:0]; return sr; end
      {OP_ARITH, FUN_ADD}:  return a + b;
      {OP_ARITH, FUN_SUB}:  return a - b;
      {OP_ARITH, FUN_SLT}:  return (sa < sb) ? 32'd1 : 32'd0;
      {OP_ARITH, FUN_SLTU}: return (a < b) ? 32'd1 : 32'd0;
      {OP_DIV, FUN_DIV}:    begin sr = sa / sb; return sr; end
      {OP_DIV, FUN_DIVU}:   return a / b;
      {OP_DIV, FUN_REM}:    begin sr = sa % sb; return sr; end
      {OP_DIV, FUN_REMU}:   return a % b;
      default:              return 32'd0;
    endcase
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [2:0] fun, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d, input logic w,
                       input logic [31:0] ew, input logic ewreg, input bit push,
                       output int waits);
    in_valid = 1'b1; aluop = op; alufun = fun; reg1 = a; reg2 = b; wd = d; wreg = w;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout in_ready=%0b want 1 within 200 cycles", in_ready);
      in_valid = 1'b0;
      sync();
    end else begin
      if (push) exp_q.push_back('{ew, d, ewreg});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    sync();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_wdata, out_wd, out_wreg, stall_req} !== '0) begin
      failures++;
      $display("FAIL reset_outputs ov=%0b wdata=%h wd=%0d wreg=%0b stall=%0b want all 0",
               out_valid, out_wdata, out_wd, out_wreg, stall_req);
    end
    rst = 1'b1;
    sync();
  endtask

  task automatic test_add();
    int w;
    issue(OP_ARITH, FUN_ADD, 32'h7FFF_FFFF, 32'h1, 5'd5, 1'b1, 32'h8000_0000, 1'b1, 1'b1, w);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL add_latency out_valid=%0b want 1", out_valid);
    end
    sync();
  endtask

  task automatic test_shift_slt();
    int w;
    issue(OP_SHIFT, FUN_SRA, 32'h8000_0000, 32'd31, 5'd6, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, w);
    issue(OP_ARITH, FUN_SLTU, 32'h1, 32'hFFFF_FFFF, 5'd7, 1'b1, 32'h1, 1'b1, 1'b1, w);
    issue(OP_NOP, 3'd0, 32'h1234, 32'h5678, 5'd8, 1'b1, 32'h0, 1'b0, 1'b1, w);
    issue(3'd7, 3'd0, 32'h1234, 32'h5678, 5'd9, 1'b1, 32'h0, 1'b0, 1'b1, w);
    issue(OP_LOGIC, 3'd5, 32'h1234, 32'h5678, 5'd10, 1'b1, 32'h0, 1'b0, 1'b1, w);
    issue(OP_ARITH, FUN_SUB, 32'h0, 32'h1, 5'd11, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, w);
    drain();
  endtask

  task automatic test_div();
    int w;
    int bad = 0;
    issue(OP_DIV, FUN_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b1, 32'hFFFF_FFFD, 1'b1, 1'b1, w);
    repeat (33) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || stall_req !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL div_stall bad_cycles=%0d want 0 (in_ready low, stall_req high for 33)", bad);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || stall_req !== 1'b0) begin
      failures++;
      $display("FAIL div_latency out_valid=%0b stall=%0b want 1 0", out_valid, stall_req);
    end
    sync();
    issue(OP_DIV, FUN_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, w);
    issue(OP_DIV, FUN_DIVU, 32'hFFFF_FFFF, 32'd10, 5'd12, 1'b1, 32'h1999_9999, 1'b1, 1'b1, w);
    drain();
  endtask

  task automatic test_special();
    int w;
    issue(OP_DIV, FUN_DIVU, 32'd5, 32'd0, 5'd13, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, w);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || stall_req !== 1'b0) begin
      failures++;
      $display("FAIL divzero_latency out_valid=%0b stall=%0b want 1 0", out_valid, stall_req);
    end
    sync();
    issue(OP_DIV, FUN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1, 32'h8000_0000, 1'b1, 1'b1, w);
    issue(OP_DIV, FUN_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1, 32'h0, 1'b1, 1'b1, w);
    issue(OP_DIV, FUN_REMU, 32'd77, 32'd0, 5'd16, 1'b1, 32'd77, 1'b1, 1'b1, w);
    issue(OP_DIV, FUN_DIV, 32'd9, 32'd0, 5'd17, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, w);
    drain();
  endtask

  task automatic test_back_to_back();
    int w;
    int total = 0;
    int bad = 0;
    out_ready = 1'b0;
    issue(OP_ARITH, FUN_ADD, 32'd3, 32'd4, 5'd18, 1'b1, 32'd7, 1'b1, 1'b1, w);
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_wdata !== 32'd7 || out_wd !== 5'd18 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL backpressure_hold bad_cycles=%0d want 0", bad);
    end
    out_ready = 1'b1;
    sync();
    for (int i = 0; i < 16; i++) begin
      logic [2:0]  op, fn;
      logic [31:0] a, b;
      case (i % 3)
        0: begin op = OP_LOGIC; fn = 3'($urandom_range(0, 2)); end
        1: begin op = OP_SHIFT; fn = 3'($urandom_range(0, 2)); end
        default: begin op = OP_ARITH; fn = 3'($urandom_range(0, 3)); end
      endcase
      a = $urandom;
      b = $urandom;
      issue(op, fn, a, b, 5'(i), 1'b1, ref_op(op, fn, a, b), 1'b1, 1'b1, w);
      total += w;
    end
    checks++;
    if (total != 0) begin
      failures++;
      $display("FAIL throughput wait_cycles=%0d want 0", total);
    end
    drain();
  endtask

  task automatic test_random_div();
    int w;
    for (int i = 0; i < 6; i++) begin
      logic [2:0]  fn;
      logic [31:0] a, b;
      fn = 3'(i % 4);
      a = $urandom;
      b = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 5) b = -32'sd13;
      issue(OP_DIV, fn, a, b, 5'(20 + i), 1'b1, ref_op(OP_DIV, fn, a, b), 1'b1, 1'b1, w);
    end
    drain();
  endtask

  task automatic test_flush();
    int w;
    int bad = 0;
    issue(OP_DIV, FUN_DIV, 32'd100, 32'd7, 5'd30, 1'b1, 32'd0, 1'b0, 1'b0, w);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || stall_req !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_state ov=%0b stall=%0b in_ready=%0b want 0 0 1", out_valid, stall_req, in_ready);
    end
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL flush_no_result valid_cycles=%0d want 0", bad);
    end
    sync();
    issue(OP_LOGIC, FUN_XOR, 32'hF0F0_0000, 32'h0FF0_FFFF, 5'd31, 1'b1, 32'hFF00_FFFF, 1'b1, 1'b1, w);
    drain();
  endtask

  task automatic test_reset_mid();
    int w;
    issue(OP_DIV, FUN_DIVU, 32'd1000, 32'd3, 5'd2, 1'b1, 32'd0, 1'b0, 1'b0, w);
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_wdata, out_wd, out_wreg, stall_req} !== '0) begin
      failures++;
      $display("FAIL async_reset ov=%0b wdata=%h wd=%0d wreg=%0b stall=%0b want all 0",
               out_valid, out_wdata, out_wd, out_wreg, stall_req);
    end
    @(negedge clk);
    rst = 1'b1;
    sync();
    issue(OP_DIV, FUN_REMU, 32'd1000, 32'd3, 5'd1, 1'b1, 32'd1, 1'b1, 1'b1, w);
    drain();
  endtask

  initial begin
    test_reset();
    test_add();
    test_shift_slt();
    test_div();
    test_special();
    test_back_to_back();
    test_random_div();
    test_flush();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected pending=%0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
